// File: rtl/flash_erase_ctrl.sv
// flash_erase_ctrl: runs one SPI-flash sector erase from a single start request.
// The sequence is WREN, then SE with a 24-bit address, then RDSR polling until WIP clears.
// The SPI bus runs in mode 3, so sck idles high.
// All outputs are registered. The frame engine and the gap timing share a single down-counter.
module flash_erase_ctrl #(
  parameter int unsigned SCK_HALF = 2,
  parameter int unsigned CS_GAP   = 8,
  parameter int unsigned POLL_MAX = 1024,
  parameter logic [7:0]  WREN_CMD = 8'h06,
  parameter logic [7:0]  SE_CMD   = 8'hD8,
  parameter logic [7:0]  RDSR_CMD = 8'h05
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] sector_addr,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN,
    S_GAP,
    S_SE,
    S_POLL,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  // LEAD: cs_n is low and sck has not fallen yet. LOW/HIGH: the two halves of each bit.
  typedef enum logic [1:0] {
    PH_LEAD,
    PH_LOW,
    PH_HIGH
  } phase_t;

  localparam int unsigned CNT_MAX = (SCK_HALF > CS_GAP) ? SCK_HALF : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned POLL_W  = $clog2(POLL_MAX + 1);

  localparam logic [CNT_W-1:0]  HALF_LOAD    = CNT_W'(SCK_HALF - 1);
  // The GAP state is entered right as cs_n rises, so it waits CS_GAP-1 more cycles.
  localparam logic [CNT_W-1:0]  GAP_LOAD     = CNT_W'(CS_GAP - 1);
  // After a poll, the CHECK cycle already counts as one of the cs_n-high cycles.
  localparam logic [CNT_W-1:0]  GAP_LOAD_CHK = CNT_W'(CS_GAP - 2);
  localparam logic [POLL_W-1:0] POLL_LAST    = POLL_W'(POLL_MAX - 1);

  state_t              state;
  state_t              gap_next;
  phase_t              phase;
  logic [CNT_W-1:0]    cnt;
  logic [4:0]          bit_cnt;
  logic [31:0]         shift;
  logic [23:0]         addr;
  logic [7:0]          status;
  logic [POLL_W-1:0]   poll_cnt;

  // Sequencer: start handshake, bit-level frame engine, cs_n gap timing and status evaluation
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      gap_next    <= S_SE;
      phase       <= PH_LEAD;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      addr        <= '0;
      status      <= '0;
      poll_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cs_n        <= 1'b1;
      sck         <= 1'b1;
      mosi        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr        <= sector_addr;
            timeout_err <= 1'b0;
            poll_cnt    <= '0;
            busy        <= 1'b1;
            state       <= S_WREN;
            cs_n        <= 1'b0;
            phase       <= PH_LEAD;
            cnt         <= HALF_LOAD;
            shift       <= {WREN_CMD, 24'h000000};
            bit_cnt     <= 5'd7;
          end
        end

        S_WREN, S_SE, S_POLL: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            unique case (phase)
              PH_LEAD: begin
                sck   <= 1'b0;
                mosi  <= shift[31];
                shift <= {shift[30:0], 1'b0};
                phase <= PH_LOW;
                cnt   <= HALF_LOAD;
              end
              PH_LOW: begin
                sck   <= 1'b1;
                phase <= PH_HIGH;
                cnt   <= HALF_LOAD;
                if (state == S_POLL && bit_cnt < 5'd8) begin
                  status <= {status[6:0], miso};
                end
              end
              PH_HIGH: begin
                if (bit_cnt == 5'd0) begin
                  cs_n  <= 1'b1;
                  sck   <= 1'b1;
                  mosi  <= 1'b0;
                  phase <= PH_LEAD;
                  if (state == S_POLL) begin
                    state <= S_CHECK;
                  end else begin
                    state    <= S_GAP;
                    cnt      <= GAP_LOAD;
                    gap_next <= (state == S_WREN) ? S_SE : S_POLL;
                  end
                end else begin
                  sck     <= 1'b0;
                  mosi    <= shift[31];
                  shift   <= {shift[30:0], 1'b0};
                  bit_cnt <= bit_cnt - 5'd1;
                  phase   <= PH_LOW;
                  cnt     <= HALF_LOAD;
                end
              end
              default: phase <= PH_LEAD;
            endcase
          end
        end

        S_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cs_n  <= 1'b0;
            phase <= PH_LEAD;
            cnt   <= HALF_LOAD;
            state <= gap_next;
            if (gap_next == S_SE) begin
              shift   <= {SE_CMD, addr};
              bit_cnt <= 5'd31;
            end else begin
              shift   <= {RDSR_CMD, 24'h000000};
              bit_cnt <= 5'd15;
            end
          end
        end

        S_CHECK: begin
          if (!status[0]) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            poll_cnt <= poll_cnt + POLL_W'(1);
            if (poll_cnt == POLL_LAST) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state       <= S_ERR;
            end else begin
              state    <= S_GAP;
              gap_next <= S_POLL;
              cnt      <= GAP_LOAD_CHK;
            end
          end
        end

        S_DONE, S_ERR: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_erase_ctrl.sv
// tb_flash_erase_ctrl: directed bench for the sector-erase sequencer.
// It uses a small SPI-flash model that logs mosi bytes and frame timing and returns scripted status bytes.
module tb_flash_erase_ctrl;

  localparam int CLK_PERIOD = 10;
  localparam logic [7:0] RDSR = 8'h05;

  logic        sys_clk;
  logic        rst_n;
  logic        start;
  logic [23:0] sector_addr;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        cs_n;
  logic        sck;
  logic        mosi;
  logic        miso;

  flash_erase_ctrl #(
    .SCK_HALF(2),
    .CS_GAP  (8),
    .POLL_MAX(4),
    .WREN_CMD(8'h06),
    .SE_CMD  (8'hD8),
    .RDSR_CMD(8'h05)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .start      (start),
    .sector_addr(sector_addr),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .cs_n       (cs_n),
    .sck        (sck),
    .mosi       (mosi),
    .miso       (miso)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Flash model and monitor state
  logic [7:0] mosi_log[$];
  logic [7:0] poll_status[$];
  int         win_q[$];
  int         lead_q[$];
  int         tail_q[$];
  int         gap_q[$];
  logic [7:0] exp_bytes[$];
  int         exp_win[$];
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] first_byte = 8'h00;
  logic [7:0] cur_status = 8'h01;
  logic [2:0] rd_idx;
  logic       frame_open = 1'b0;
  logic       rise_valid = 1'b0;
  int         fall_in_frame = 0;
  int         rise_in_frame = 0;
  int         poll_frames = 0;
  int         done_cnt = 0;
  int         both_cnt = 0;
  int         busy_with_done = 0;
  time        t_cs_fall = 0;
  time        t_cs_rise = 0;
  time        t_first_fall = 0;
  time        t_last_rise = 0;

  // Free-running system clock
  initial sys_clk = 1'b0;
  always #(CLK_PERIOD / 2) sys_clk = ~sys_clk;

  // Frame start: record the gap since the previous frame and pick the status byte to return
  always @(negedge cs_n) begin
    if (rise_valid) gap_q.push_back(int'((($time - t_cs_rise)) / CLK_PERIOD));
    t_cs_fall     = $time;
    frame_open    = 1'b1;
    fall_in_frame = 0;
    rise_in_frame = 0;
    first_byte    = 8'h00;
    cur_status    = (poll_status.size() > 0) ? poll_status[0] : 8'h01;
  end

  // Flash shifts status out on sck falls during the RDSR read byte and holds miso high otherwise
  always @(negedge sck) begin
    if (cs_n === 1'b0) begin
      if (fall_in_frame == 0) t_first_fall = $time;
      if (fall_in_frame >= 8 && fall_in_frame < 16 && first_byte == RDSR) begin
        rd_idx = 3'(15 - fall_in_frame);
        miso   = cur_status[rd_idx];
      end else begin
        miso = 1'b1;
      end
      fall_in_frame++;
    end
  end

  // Flash samples mosi on sck rises and collects whole bytes
  always @(posedge sck) begin
    if (cs_n === 1'b0) begin
      cur_byte    = {cur_byte[6:0], mosi};
      rise_in_frame++;
      t_last_rise = $time;
      if (rise_in_frame % 8 == 0) begin
        mosi_log.push_back(cur_byte);
        if (rise_in_frame == 8) first_byte = cur_byte;
      end
    end
  end

  // Frame end: record the window, lead and tail times and move to the next scripted status
  always @(posedge cs_n) begin
    if (frame_open) begin
      win_q.push_back(int'(($time - t_cs_fall) / CLK_PERIOD));
      lead_q.push_back(int'((t_first_fall - t_cs_fall) / CLK_PERIOD));
      tail_q.push_back(int'(($time - t_last_rise) / CLK_PERIOD));
      if (first_byte == RDSR) begin
        poll_frames++;
        if (poll_status.size() > 0) void'(poll_status.pop_front());
      end
    end
    frame_open = 1'b0;
    t_cs_rise  = $time;
    rise_valid = 1'b1;
  end

  // Completion pulse bookkeeping
  always @(posedge sys_clk) begin
    if (done === 1'b1) done_cnt++;
    if (done === 1'b1 && timeout_err === 1'b1) both_cnt++;
    if (done === 1'b1 && busy === 1'b1) busy_with_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    mosi_log.delete();
    poll_status.delete();
    win_q.delete();
    lead_q.delete();
    tail_q.delete();
    gap_q.delete();
    rise_valid  = 1'b0;
    poll_frames = 0;
    done_cnt    = 0;
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, 32'(mosi_log.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'((i < mosi_log.size()) ? mosi_log[i] : 8'hxx),
            32'(exp_bytes[i]));
    end
  endtask

  task automatic check_windows(input string tag);
    check({tag, "_frames"}, 32'(win_q.size()), 32'(exp_win.size()));
    for (int i = 0; i < exp_win.size(); i++) begin
      check($sformatf("%s_win%0d", tag, i), (i < win_q.size()) ? 32'(win_q[i]) : 32'hxxxxxxxx,
            32'(exp_win[i]));
    end
  endtask

  task automatic launch(input logic [23:0] a);
    start       = 1'b1;
    sector_addr = a;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n = 0;
    while (!(done === 1'b1 || timeout_err === 1'b1) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, 32'(done === 1'b1 || timeout_err === 1'b1), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    sector_addr = 24'h000000;
    miso        = 1'b1;

    // Reset values
    repeat (3) @(negedge sys_clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sck", 32'(sck), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // WIP=1,1,0 at address ABCDEF, with the full bus timing checked
    $display("[TB] full erase with two busy polls");
    clear_logs();
    poll_status = '{8'h03, 8'h01, 8'h00};
    launch(24'hABCDEF);
    check("t1_busy_after_accept", 32'(busy), 32'd1);
    check("t1_cs_n_low", 32'(cs_n), 32'd0);
    wait_end(3000, "t1_finished");
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_with_done", 32'(busy), 32'd0);
    check("t1_timeout_err", 32'(timeout_err), 32'd0);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    check("t1_start_in_done_ignored", 32'(busy), 32'd0);
    repeat (3) @(negedge sys_clk);
    check("t1_idle_cs_n", 32'(cs_n), 32'd1);
    check("t1_done_count", 32'(done_cnt), 32'd1);
    check("t1_status_reg", 32'(dut.status), 32'h00);
    exp_bytes = '{8'h06, 8'hD8, 8'hAB, 8'hCD, 8'hEF, 8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
    check_bytes("t1_mosi");
    exp_win = '{34, 130, 66, 66, 66};
    check_windows("t2");
    for (int i = 0; i < lead_q.size(); i++) check($sformatf("t2_lead%0d", i), 32'(lead_q[i]), 32'd2);
    for (int i = 0; i < tail_q.size(); i++) check($sformatf("t2_tail%0d", i), 32'(tail_q[i]), 32'd2);
    check("t2_gap_count", 32'(gap_q.size()), 32'd4);
    for (int i = 0; i < gap_q.size(); i++) check($sformatf("t2_gap%0d", i), 32'(gap_q[i]), 32'd8);

    // WIP stuck at 1 with POLL_MAX=4
    $display("[TB] poll timeout");
    clear_logs();
    launch(24'h123456);
    wait_end(3000, "t3_finished");
    check("t3_timeout_err", 32'(timeout_err), 32'd1);
    check("t3_no_done", 32'(done), 32'd0);
    check("t3_busy_with_err", 32'(busy), 32'd0);
    repeat (5) @(negedge sys_clk);
    check("t3_timeout_sticky", 32'(timeout_err), 32'd1);
    check("t3_poll_frames", 32'(poll_frames), 32'd4);
    check("t3_done_count", 32'(done_cnt), 32'd0);
    exp_win = '{34, 130, 66, 66, 66, 66};
    check_windows("t3");

    // A start pulse during the SE frame is ignored. The new start clears timeout_err.
    $display("[TB] start while busy");
    clear_logs();
    poll_status = '{8'h00};
    launch(24'h5A5A5A);
    check("t4_timeout_cleared", 32'(timeout_err), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    repeat (50) @(negedge sys_clk);
    check("t4_in_se_frame", 32'(cs_n), 32'd0);
    start       = 1'b1;
    sector_addr = 24'hFFFFFF;
    @(negedge sys_clk);
    start = 1'b0;
    wait_end(3000, "t4_finished");
    check("t4_done", 32'(done), 32'd1);
    repeat (4) @(negedge sys_clk);
    check("t4_done_count", 32'(done_cnt), 32'd1);
    check("t4_busy_after", 32'(busy), 32'd0);
    exp_bytes = '{8'h06, 8'hD8, 8'h5A, 8'h5A, 8'h5A, 8'h05, 8'h00};
    check_bytes("t4_mosi");

    // Asynchronous reset in the middle of SE, just after the AB byte
    $display("[TB] reset mid-SE");
    clear_logs();
    poll_status = '{8'h00};
    launch(24'hABCDEF);
    repeat (108) @(negedge sys_clk);
    check("t5_pre_cs_n", 32'(cs_n), 32'd0);
    check("t5_pre_sck", 32'(sck), 32'd0);
    check("t5_pre_mosi", 32'(mosi), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_cs_n", 32'(cs_n), 32'd1);
    check("t5_async_sck", 32'(sck), 32'd1);
    check("t5_async_mosi", 32'(mosi), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    exp_bytes = '{8'h06, 8'hD8, 8'hAB};
    check_bytes("t5_partial");
    repeat (3) @(negedge sys_clk);
    check("t5_no_done", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    clear_logs();
    poll_status = '{8'h00};
    launch(24'h00FF10);
    wait_end(3000, "t5_restart_finished");
    check("t5_restart_done", 32'(done), 32'd1);
    repeat (4) @(negedge sys_clk);
    check("t5_restart_done_count", 32'(done_cnt), 32'd1);
    exp_bytes = '{8'h06, 8'hD8, 8'h00, 8'hFF, 8'h10, 8'h05, 8'h00};
    check_bytes("t5_mosi");
    exp_win = '{34, 130, 66};
    check_windows("t5");

    // Status A4h (WIP=0) is sampled MSB first on sck rises
    $display("[TB] status sampling");
    clear_logs();
    poll_status = '{8'hA4};
    launch(24'h000001);
    wait_end(3000, "t6_finished");
    check("t6_done", 32'(done), 32'd1);
    check("t6_timeout_err", 32'(timeout_err), 32'd0);
    check("t6_status_reg", 32'(dut.status), 32'hA4);
    repeat (4) @(negedge sys_clk);
    check("t6_poll_frames", 32'(poll_frames), 32'd1);
    check("t6_done_count", 32'(done_cnt), 32'd1);

    // Global boundary properties
    check("done_and_timeout_together", 32'(both_cnt), 32'd0);
    check("busy_during_done", 32'(busy_with_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
